// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and unified memory bus of mem_arbiter
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ready;
   logic          if_stall;

   logic          d_rd;
   logic          d_wr;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          d_stall;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of fetch and data ports onto one fixed-latency memory
module mem_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input logic         clk,
   input logic         rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {FETCH, DATA} port_t;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_t        state_q, state_d;
   port_t         grant_q, grant_d;
   port_t         last_grant_q, last_grant_d;
   port_t         pick;
   logic          store_q, store_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          if_ready_q, if_ready_d;
   logic          d_ready_q, d_ready_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          d_req;

   assign d_req = bus.d_rd | bus.d_wr;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      store_d      = store_q;
      cnt_d        = cnt_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_ready_d   = 1'b0;
      d_ready_d    = 1'b0;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      // On a tie the port that did not win last time gets the memory.
      pick = (d_req && (!bus.if_req || last_grant_q == FETCH)) ? DATA : FETCH;

      case (state_q)
         IDLE: begin
            if (bus.if_req || d_req) begin
               grant_d      = pick;
               last_grant_d = pick;
               store_d      = (pick == DATA) && bus.d_wr;
               mem_en_d     = 1'b1;
               mem_we_d     = (pick == DATA) && bus.d_wr;
               mem_addr_d   = (pick == DATA) ? bus.d_addr : bus.if_addr;
               if (pick == DATA) mem_wdata_d = bus.d_wdata;
               cnt_d        = LAT_C;
               state_d      = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               if (grant_q == FETCH) begin
                  if_rdata_d = bus.mem_rdata;
                  if_ready_d = 1'b1;
               end else begin
                  if (!store_q) d_rdata_d = bus.mem_rdata;
                  d_ready_d = 1'b1;
               end
               state_d = RESP;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= FETCH;
         last_grant_q <= FETCH;
         store_q      <= 1'b0;
         cnt_q        <= 4'd0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_ready_q   <= 1'b0;
         d_ready_q    <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         store_q      <= store_d;
         cnt_q        <= cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_ready_q   <= if_ready_d;
         d_ready_q    <= d_ready_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_stall  = bus.if_req & ~if_ready_q;
   assign bus.d_stall   = d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter at LAT=2, 1 and 7
module tb_mem_arbiter;
   localparam logic [31:0] POISON = 32'hBAD0BAD0;

   logic clk = 1'b0;
   logic rst;
   int   n_asserts = 0;
   int   n_fail    = 0;
   int   lat1, lat2, lat7;
   logic [31:0] r1, r2, r7;

   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
   mem_arbiter_if #(.AW(32), .DW(32)) b2 ();
   mem_arbiter_if #(.AW(32), .DW(32)) b7 ();

   mem_arbiter #(.AW(32), .DW(32), .LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   mem_arbiter #(.AW(32), .DW(32), .LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   mem_arbiter #(.AW(32), .DW(32), .LAT(7)) dut7 (.clk(clk), .rst(rst), .bus(b7));

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return 32'h00500083 ^ a;
   endfunction

   // Read data exists only in cycle (mem_en cycle + LAT); any other cycle shows POISON.
   logic [31:0] p1 [0:15];
   logic [31:0] p2 [0:15];
   logic [31:0] p7 [0:15];
   always @(posedge clk) begin
      for (int i = 15; i > 0; i--) begin
         p1[i] <= p1[i-1];
         p2[i] <= p2[i-1];
         p7[i] <= p7[i-1];
      end
      p1[0] <= b1.mem_en ? rd_word(b1.mem_addr) : POISON;
      p2[0] <= b2.mem_en ? rd_word(b2.mem_addr) : POISON;
      p7[0] <= b7.mem_en ? rd_word(b7.mem_addr) : POISON;
   end
   assign b1.mem_rdata = p1[0];
   assign b2.mem_rdata = p2[1];
   assign b7.mem_rdata = p7[6];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      b1.if_req = 0; b1.if_addr = 0; b1.d_rd = 0; b1.d_wr = 0; b1.d_addr = 0; b1.d_wdata = 0;
      b2.if_req = 0; b2.if_addr = 0; b2.d_rd = 0; b2.d_wr = 0; b2.d_addr = 0; b2.d_wdata = 0;
      b7.if_req = 0; b7.if_addr = 0; b7.d_rd = 0; b7.d_wr = 0; b7.d_addr = 0; b7.d_wdata = 0;
      rst = 1;
      tick; tick;
      chk("rst_mem_en", b2.mem_en, 0);
      chk("rst_mem_we", b2.mem_we, 0);
      chk("rst_mem_addr", b2.mem_addr, 0);
      chk("rst_readies", {b2.if_ready, b2.d_ready}, 0);
      chk("rst_if_rdata", b2.if_rdata, 0);
      chk("rst_d_rdata", b2.d_rdata, 0);
      rst = 0;
      tick;

      // single fetch
      b2.if_req = 1; b2.if_addr = 32'h10;
      #1;
      chk("f_stall_c0", b2.if_stall, 1);
      chk("f_mem_en_c0", b2.mem_en, 0);
      tick;
      chk("f_mem_en_c1", b2.mem_en, 1);
      chk("f_mem_addr_c1", b2.mem_addr, 32'h10);
      chk("f_mem_we_c1", b2.mem_we, 0);
      chk("f_stall_c1", b2.if_stall, 1);
      tick;
      chk("f_mem_en_c2", b2.mem_en, 0);
      chk("f_stall_c2", b2.if_stall, 1);
      tick;
      chk("f_ready_c3", b2.if_ready, 0);
      chk("f_stall_c3", b2.if_stall, 1);
      tick;
      chk("f_ready_c4", b2.if_ready, 1);
      chk("f_rdata_c4", b2.if_rdata, 32'h00500093);
      chk("f_stall_c4", b2.if_stall, 0);
      tick;
      b2.if_req = 0;
      #1;
      chk("f_ready_c5", b2.if_ready, 0);

      // single store
      b2.d_wr = 1; b2.d_addr = 32'h40; b2.d_wdata = 32'hDEADBEEF;
      tick;
      chk("s_mem_en_c1", b2.mem_en, 1);
      chk("s_mem_we_c1", b2.mem_we, 1);
      chk("s_mem_addr_c1", b2.mem_addr, 32'h40);
      chk("s_mem_wdata_c1", b2.mem_wdata, 32'hDEADBEEF);
      tick;
      chk("s_mem_en_we_c2", {b2.mem_en, b2.mem_we}, 0);
      tick;
      chk("s_stall_c3", b2.d_stall, 1);
      tick;
      chk("s_ready_c4", b2.d_ready, 1);
      chk("s_rdata_c4", b2.d_rdata, 0);
      chk("s_stall_c4", b2.d_stall, 0);
      chk("s_mem_addr_c4", b2.mem_addr, 32'h40);
      tick;
      b2.d_wr = 0;

      // contention right after reset: data first, then fetch, then data again
      rst = 1;
      tick;
      rst = 0;
      b2.if_req = 1; b2.if_addr = 32'h20; b2.d_rd = 1; b2.d_addr = 32'h30;
      tick;
      chk("t_mem_addr_c1", b2.mem_addr, 32'h30);
      chk("t_mem_en_c1", b2.mem_en, 1);
      repeat (3) tick;
      chk("t_d_ready_c4", b2.d_ready, 1);
      chk("t_d_rdata_c4", b2.d_rdata, rd_word(32'h30));
      chk("t_if_stall_c4", b2.if_stall, 1);
      tick;
      b2.d_rd = 0;
      #1;
      chk("t_mem_en_c5", b2.mem_en, 0);
      tick;
      chk("t_mem_en_c6", b2.mem_en, 1);
      chk("t_mem_addr_c6", b2.mem_addr, 32'h20);
      repeat (3) tick;
      chk("t_if_ready_c9", b2.if_ready, 1);
      chk("t_if_rdata_c9", b2.if_rdata, rd_word(32'h20));
      chk("t_d_rdata_kept_c9", b2.d_rdata, rd_word(32'h30));
      tick;
      b2.if_addr = 32'h24; b2.d_rd = 1; b2.d_addr = 32'h34;
      tick;
      chk("t3_mem_addr", b2.mem_addr, 32'h34);
      repeat (3) tick;
      chk("t3_d_ready", b2.d_ready, 1);
      chk("t3_d_rdata", b2.d_rdata, rd_word(32'h34));
      tick;
      b2.d_rd = 0;

      // continuous fetch; load raised during fetch WAIT waits for IDLE
      tick;
      chk("c_mem_addr_f24", b2.mem_addr, 32'h24);
      tick;
      b2.d_rd = 1; b2.d_addr = 32'h38;
      #1;
      chk("c_d_stall_wait", b2.d_stall, 1);
      tick;
      chk("c_mem_en_wait", b2.mem_en, 0);
      tick;
      chk("c_if_ready_f24", b2.if_ready, 1);
      chk("c_if_rdata_f24", b2.if_rdata, rd_word(32'h24));
      chk("c_mem_en_resp", b2.mem_en, 0);
      tick;
      b2.if_addr = 32'h28;
      tick;
      chk("c_mem_addr_l38", b2.mem_addr, 32'h38);
      chk("c_mem_en_l38", b2.mem_en, 1);
      repeat (3) tick;
      chk("c_d_ready_l38", b2.d_ready, 1);
      chk("c_d_rdata_l38", b2.d_rdata, rd_word(32'h38));
      chk("c_if_stall_l38", b2.if_stall, 1);
      tick;
      b2.d_rd = 0;
      tick;
      chk("c_mem_addr_f28", b2.mem_addr, 32'h28);
      repeat (3) tick;
      chk("c_if_ready_f28", b2.if_ready, 1);
      chk("c_if_rdata_f28", b2.if_rdata, rd_word(32'h28));
      tick;
      b2.if_req = 0;

      // d_rd and d_wr together are a store
      b2.d_rd = 1; b2.d_wr = 1; b2.d_addr = 32'h8; b2.d_wdata = 32'h12345678;
      tick;
      chk("rw_mem_en", b2.mem_en, 1);
      chk("rw_mem_we", b2.mem_we, 1);
      chk("rw_mem_addr", b2.mem_addr, 32'h8);
      chk("rw_mem_wdata", b2.mem_wdata, 32'h12345678);
      repeat (3) tick;
      chk("rw_d_ready", b2.d_ready, 1);
      chk("rw_d_rdata_kept", b2.d_rdata, rd_word(32'h38));
      tick;
      b2.d_rd = 0; b2.d_wr = 0;
      #1;
      chk("rw_d_ready_once", b2.d_ready, 0);
      tick;
      chk("rw_no_second_access", b2.mem_en, 0);

      // reset during WAIT on all three latencies
      b2.if_req = 1; b2.if_addr = 32'h44;
      b1.if_req = 1; b1.if_addr = 32'h14;
      b7.if_req = 1; b7.if_addr = 32'h74;
      tick; tick;
      rst = 1;
      #1;
      chk("mr_mem_en", {b1.mem_en, b2.mem_en, b7.mem_en}, 0);
      chk("mr_mem_we", {b1.mem_we, b2.mem_we, b7.mem_we}, 0);
      chk("mr_readies", {b1.if_ready, b2.if_ready, b7.if_ready, b2.d_ready}, 0);
      chk("mr_mem_addr", b2.mem_addr, 0);
      chk("mr_if_rdata", b2.if_rdata, 0);
      tick;
      rst = 0;
      b1.if_req = 0; b2.if_req = 0; b7.if_req = 0;
      for (int k = 0; k < 10; k++) begin
         tick;
         chk("mr_no_ready", {b1.if_ready, b2.if_ready, b7.if_ready}, 0);
      end

      b2.if_req = 1; b2.if_addr = 32'h50;
      b1.if_req = 1; b1.if_addr = 32'h18;
      b7.if_req = 1; b7.if_addr = 32'h78;
      lat1 = -1; lat2 = -1; lat7 = -1;
      r1 = 0; r2 = 0; r7 = 0;
      for (int k = 1; k <= 14; k++) begin
         tick;
         if (b1.if_ready && lat1 < 0) begin lat1 = k; r1 = b1.if_rdata; b1.if_req = 0; end
         if (b2.if_ready && lat2 < 0) begin lat2 = k; r2 = b2.if_rdata; b2.if_req = 0; end
         if (b7.if_ready && lat7 < 0) begin lat7 = k; r7 = b7.if_rdata; b7.if_req = 0; end
      end
      chk("lat_lat2", 32'(lat2), 4);
      chk("lat_lat1", 32'(lat1), 3);
      chk("lat_lat7", 32'(lat7), 9);
      chk("lat_rdata2", r2, rd_word(32'h50));
      chk("lat_rdata1", r1, rd_word(32'h18));
      chk("lat_rdata7", r7, rd_word(32'h78));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-ported unified memory between the instruction-fetch port and the data (load/store) port of the pipelined RISC-V core.
- Fixed-latency memory model: read data is valid LAT cycles after the mem_en strobe.
- Round-robin arbitration on contention, so neither port starves.
- Per-port stall outputs freeze the IF and MEM pipeline stages while a port's request is pending.

Parameters:
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width (whole-word accesses only)
- LAT, 2, memory read latency in cycles after the mem_en cycle; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active high
- if_req  input  1  fetch request; held high until if_ready
- if_addr  input  AW  fetch address; stable while if_req is high
- if_rdata  output  DW  fetched instruction; held until the next fetch response
- if_ready  output  1  one-cycle completion pulse for fetch
- if_stall  output  1  if_req & ~if_ready (combinational)
- d_rd  input  1  load request
- d_wr  input  1  store request
- d_addr  input  AW  data address; stable while the request is high
- d_wdata  input  DW  store data; stable while the request is high
- d_rdata  output  DW  load data; held until the next data response
- d_ready  output  1  one-cycle completion pulse for a load or store
- d_stall  output  1  (d_rd|d_wr) & ~d_ready (combinational)
- mem_en  output  1  one-cycle access strobe
- mem_we  output  1  write enable; qualified by mem_en
- mem_addr  output  AW  access address; held for the whole transaction
- mem_wdata  output  DW  write data; held for the whole transaction
- mem_rdata  input  DW  memory read data; valid in cycle (mem_en cycle + LAT)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state=IDLE; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; if_ready=0, d_ready=0; if_rdata=0, d_rdata=0; cnt=0; last_grant=FETCH.
- Reset mid-transaction: abandon the transaction, clear all outputs to reset values, return to IDLE, issue no ready pulse.
- Sequential outputs are all registered; only the stall outputs are combinational.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, cycle T, no request: stay in IDLE.
- IDLE, cycle T, request present:
  - Pick a winner; latch grant, addr, we and wdata into the mem_* registers.
  - Set cnt<=LAT and go to ISSUE.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port not equal to last_grant wins.
  - last_grant updates on every grant.
  - After reset, data wins the first tie.
- d_rd and d_wr both high: the request is a store (d_wr wins).
- ISSUE (T+1):
  - mem_en=1 for exactly this cycle; mem_we=1 for a store.
  - Go to WAIT; cnt counts down to 1.
- WAIT:
  - Decrement cnt each cycle.
  - When cnt==1: capture mem_rdata into the granted port's rdata register (loads and fetches only), then go to RESP.
  - Capture cycle = T+1+LAT.
- RESP (T+2+LAT):
  - Granted port's ready=1 for this cycle only.
  - Non-granted port's rdata is unchanged.
  - Store: d_rdata is unchanged.
  - Requests are ignored this cycle; go to IDLE.
- Requester rule: drop the request, or present a new one, in the cycle after seeing ready. IDLE samples requests again at T+3+LAT.
- Timing:
  - Request-to-ready latency is LAT+2 cycles.
  - Peak throughput is one access per LAT+3 cycles.
  - With LAT=2: latency 4, and back-to-back accesses to one port start every 5 cycles.
- mem_addr and mem_wdata are held from ISSUE through RESP; mem_we drops with mem_en.
- A request that loses arbitration stays pending and its stall stays high. It is granted at the next IDLE.
- A request raised during ISSUE, WAIT or RESP is not sampled until IDLE.
- Address and data are passed through untouched; no alignment checks.

Test Plan:
- Single fetch, LAT=2: reset, if_req=1 with if_addr=0x10 at cycle 0; memory returns 0x00500093.
  - Required: mem_en pulse at cycle 1 with mem_addr=0x10, mem_we=0.
  - Required: if_ready pulse at cycle 4 with if_rdata=0x00500093; if_stall high for cycles 0-3.
- Single store: d_wr=1, d_addr=0x40, d_wdata=0xDEADBEEF.
  - Required: mem_en=mem_we=1 for exactly one cycle with mem_addr=0x40 and mem_wdata=0xDEADBEEF.
  - Required: d_ready 4 cycles after the request; d_rdata unchanged.
- Contention after reset: if_req and d_rd raised in the same cycle and held.
  - Required: data granted first, d_ready at cycle 4.
  - Required: fetch granted at the next IDLE (cycle 5), if_ready at cycle 9.
  - Required: a third tie grants data again.
- Continuous fetch with a load raised during a fetch WAIT: the load is not sampled until IDLE. If both are pending at IDLE, grants alternate fetch/load/fetch; neither port waits more than 2 transactions.
- d_rd=d_wr=1 at address 0x8: required a single write access (mem_we=1) and one d_ready pulse.
- Reset mid-transaction: assert rst during WAIT.
  - Required: mem_en, mem_we and the ready outputs read 0 immediately; no ready pulse follows.
  - Required: after rst drops, a new fetch completes in LAT+2 cycles.
  - Required: repeat with LAT=1 and LAT=7 and check latencies 3 and 9.
